// File: rtl/logit_cordic.sv
// logit_cordic: logit(p) = 2*atanh(2p-1) via one reused hyperbolic CORDIC vectoring stage, one micro-rotation per clock.
// Define LOGIT_SAT_EN to enable out_range detection and prob==0 / prob>=1.0 saturation.
module logit_cordic #(
  parameter int ITER_MAX = 15,
  parameter int GUARD = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        prob,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] logit,
  output logic               out_range,
  output logic               busy
);
  localparam int W = 18 + GUARD;
  localparam int NSTEP = ITER_MAX + (ITER_MAX >= 13 ? 2 : ITER_MAX >= 4 ? 1 : 0);
  localparam logic signed [W-1:0] ONE = {18'sd16384, {GUARD{1'b0}}};
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state, state_n;
  logic signed [W-1:0] x, y, xs, ys, x_n, y_n;
  logic signed [31:0] z, z_n, t;
  logic signed [17:0] y0;
  logic [4:0] step, sh;
  logic accept, last, sat_lo, sat_hi, range_c, lo_c, hi_c;
  function automatic logic signed [31:0] tval(input logic [4:0] i);
    case (i)
      5'd1: tval = 32'sd589812981;
      5'd2: tval = 32'sd274247419;
      5'd3: tval = 32'sd134923406;
      5'd4: tval = 32'sd67196451;
      5'd5: tval = 32'sd33565361;
      5'd6: tval = 32'sd16778582;
      5'd7: tval = 32'sd8388779;
      5'd8: tval = 32'sd4194325;
      5'd9: tval = 32'sd2097155;
      default: tval = 32'sd1 <<< (5'd30 - i);
    endcase
  endfunction
`ifdef LOGIT_SAT_EN
  assign range_c = prob < 16'd1583 || prob > 16'd14801;
  assign lo_c = prob == 16'd0;
  assign hi_c = prob >= 16'd16384;
`else
  assign range_c = 1'b0;
  assign lo_c = 1'b0;
  assign hi_c = 1'b0;
`endif
  assign y0 = signed'({1'b0, prob, 1'b0}) - 18'sd16384;
  assign accept = in_valid & in_ready;
  assign last = step == 5'(NSTEP - 1);
  assign in_ready = state == IDLE && !reset;
  assign busy = state != IDLE;
  // shift indices 4 and 13 are applied twice to keep the hyperbolic iteration convergent
  always_comb begin
    sh = step < 5'd4 ? step + 5'd1 : step < 5'd14 ? step : step - 5'd1;
    xs = x >>> sh;
    ys = y >>> sh;
    t = tval(sh);
    x_n = y[W-1] ? x + ys : x - ys;
    y_n = y[W-1] ? y + xs : y - xs;
    z_n = y[W-1] ? z - t : z + t;
  end
  always_comb begin
    state_n = state == IDLE ? (accept ? ITER : IDLE) :
              state == ITER ? (last ? DONE : ITER) :
              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      x <= '0;
      y <= '0;
      z <= '0;
      step <= '0;
      sat_lo <= 1'b0;
      sat_hi <= 1'b0;
      out_valid <= 1'b0;
      out_range <= 1'b0;
      logit <= '0;
    end else if (accept) begin
      x <= ONE;
      y <= {y0, {GUARD{1'b0}}};
      z <= '0;
      step <= '0;
      sat_lo <= lo_c;
      sat_hi <= hi_c;
      out_range <= range_c;
    end else if (state == ITER) begin
      x <= x_n;
      y <= y_n;
      z <= z_n;
      step <= step + 5'd1;
      if (last) begin
        out_valid <= 1'b1;
        logit <= sat_lo ? 32'sh8000_0000 : sat_hi ? 32'sh7fff_ffff : z_n;
      end
    end else if (state == DONE && out_ready) out_valid <= 1'b0;
  end
endmodule

// File: tb/tb_logit_cordic.sv
// tb_logit_cordic: table vectors, handshake corner sequences and random probabilities against a real-arithmetic logit model.
module tb_logit_cordic;
  localparam int K_NEAR = 0, K_EXACT = 1, K_NEG = 2, K_POS = 3, K_NONE = 4;
  localparam longint TOL = 131072;
  typedef struct {
    logic [15:0] p;
    int          kind;
    longint      expv;
    logic        rng;
  } vec_t;
  logic clock = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, out_range, busy;
  logic [15:0] prob;
  logic signed [31:0] logit;
  int n_vec = 0, n_bad = 0;
  vec_t tbl[$];
  always #5 clock = ~clock;
  logit_cordic dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .prob(prob),
    .out_valid(out_valid), .out_ready(out_ready), .logit(logit), .out_range(out_range), .busy(busy)
  );
  function automatic longint ref_logit(input int p);
    real q;
    q = real'(p) / 16384.0;
    return longint'($ln(q / (1.0 - q)) * 536870912.0);
  endfunction
  function automatic logic ref_rng(input int p);
`ifdef LOGIT_SAT_EN
    return p < 1583 || p > 14801;
`else
    return p < 0;
`endif
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_near(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act > exp + TOL || act < exp - TOL) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, TOL);
    end
  endtask
  task automatic xact(input logic [15:0] p, output logic signed [31:0] l, output logic r, output int lat);
    int w = 0, rdy = 0;
    prob = p;
    in_valid = 1'b1;
    while (!in_ready && w < 60) begin
      tick();
      w++;
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy++;
      tick();
      lat++;
    end
    chk($sformatf("in_ready while busy p=%0d", p), rdy, 0);
    l = logit;
    r = out_range;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic signed [31:0] l, saved;
    logic r;
    int lat, bad, got, k;
    int t_out[4];
    logic [15:0] b2b[4];
    b2b = '{16'd3000, 16'd7000, 16'd10000, 16'd13500};
    tbl.push_back('{16'd8192, K_NEAR, 0, 1'b0});
    tbl.push_back('{16'd12288, K_NEAR, 589812981, 1'b0});
    tbl.push_back('{16'd4096, K_NEAR, -589812981, 1'b0});
    tbl.push_back('{16'd1583, K_NEAR, ref_logit(1583), ref_rng(1583)});
    tbl.push_back('{16'd14801, K_NEAR, ref_logit(14801), ref_rng(14801)});
    tbl.push_back('{16'd2000, K_NEAR, ref_logit(2000), ref_rng(2000)});
    tbl.push_back('{16'd1000, K_NEG, 0, ref_rng(1000)});
    tbl.push_back('{16'd1582, K_NEG, 0, ref_rng(1582)});
    tbl.push_back('{16'd14802, K_POS, 0, ref_rng(14802)});
`ifdef LOGIT_SAT_EN
    tbl.push_back('{16'd0, K_EXACT, -64'sd2147483648, 1'b1});
    tbl.push_back('{16'd16384, K_EXACT, 64'sd2147483647, 1'b1});
    tbl.push_back('{16'd65535, K_EXACT, 64'sd2147483647, 1'b1});
`else
    tbl.push_back('{16'd0, K_NONE, 0, 1'b0});
    tbl.push_back('{16'd16384, K_NONE, 0, 1'b0});
`endif
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    prob = '0;
    repeat (3) tick();
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset logit", logit, 0);
    chk("reset out_range", out_range, 0);
    reset = 1'b0;
    #1;
    chk("in_ready after reset", in_ready, 1);
    foreach (tbl[i]) begin
      xact(tbl[i].p, l, r, lat);
      chk($sformatf("latency p=%0d", tbl[i].p), lat, 17);
      chk($sformatf("out_range p=%0d", tbl[i].p), r, tbl[i].rng);
      case (tbl[i].kind)
        K_NEAR: chk_near($sformatf("logit p=%0d", tbl[i].p), l, tbl[i].expv);
        K_EXACT: chk($sformatf("saturated logit p=%0d", tbl[i].p), l, tbl[i].expv);
        K_NEG: chk($sformatf("logit negative p=%0d", tbl[i].p), l < 0, 1);
        K_POS: chk($sformatf("logit positive p=%0d", tbl[i].p), l > 0, 1);
        default: ;
      endcase
    end
    tick();
    out_ready = 1'b0;
    xact(16'd12288, l, r, lat);
    chk("bp latency", lat, 17);
    chk_near("bp logit", l, 589812981);
    saved = l;
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      prob = 16'd2000;
      tick();
      chk($sformatf("bp out_valid held c=%0d", c), out_valid, 1);
      chk($sformatf("bp logit stable c=%0d", c), logit, saved);
      chk($sformatf("bp in_ready c=%0d", c), in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp release out_valid", out_valid, 0);
    chk("bp release in_ready", in_ready, 1);
    bad = 0;
    repeat (20) begin
      tick();
      if (busy || out_valid) bad++;
    end
    chk("bp ignored in_valid pulses", bad, 0);
    prob = 16'd12288;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("abort run started", busy, 1);
    repeat (7) tick();
    reset = 1'b1;
    #1;
    chk("abort in_ready during reset", in_ready, 0);
    tick();
    chk("abort busy", busy, 0);
    chk("abort out_valid", out_valid, 0);
    reset = 1'b0;
    #1;
    chk("abort in_ready after reset", in_ready, 1);
    bad = 0;
    repeat (25) begin
      tick();
      if (out_valid) bad++;
    end
    chk("abort no result", bad, 0);
    xact(16'd8192, l, r, lat);
    chk("post-abort latency", lat, 17);
    chk_near("post-abort logit", l, 0);
    tick();
    got = 0;
    k = 0;
    prob = b2b[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && got < 4; c++) begin
      logic acc;
      if (out_valid) begin
        chk_near($sformatf("b2b logit p=%0d", b2b[got]), logit, ref_logit(b2b[got]));
        t_out[got] = c;
        got++;
      end
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        k++;
        if (k < 4) prob = b2b[k];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b result count", got, 4);
    for (int j = 1; j < 4; j++) chk($sformatf("b2b spacing %0d", j), t_out[j] - t_out[j-1], 19);
    tick();
    for (int n = 0; n < 20; n++) begin
      logic [15:0] p;
      p = 16'($urandom_range(14700, 1700));
      xact(p, l, r, lat);
      chk($sformatf("rand latency p=%0d", p), lat, 17);
      chk($sformatf("rand out_range p=%0d", p), r, 0);
      chk_near($sformatf("rand logit p=%0d", p), l, ref_logit(p));
    end
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
